// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master side is the operand producer and the result consumer.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder reusing a DIGIT-bit slice over WIDTH/DIGIT clocks, with carry, overflow and handshakes.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (A-B via inverted B and carry-in of 1).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT:0]   slice_full;
  logic             slice_cmsb;

  assign slice_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  // Carry into the slice MSB recovered from its sum bit; on the last step this is the MSB column.
  assign slice_cmsb = slice_full[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

`ifndef SERIAL_ADDER_SUB_EN
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (WIDTH'(slice_full[DIGIT-1:0]) << (WIDTH - DIGIT)) | (sum_q >> DIGIT);
        carry_d = slice_full[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          cout_d  = slice_full[DIGIT];
          ovf_d   = slice_cmsb ^ slice_full[DIGIT];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 with DIGIT=1 (main) and DIGIT=4 (latency/values).
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(8)) bus4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pops one expected result per completed output handshake.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", bus8.sum);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_sum", 32'(bus8.sum), 32'(e.sum));
        chk("sb_cout", 32'(bus8.cout), 32'(e.cout));
        chk("sb_ovf", 32'(bus8.ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_result(input int exp_lat);
    int lat;
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  // Called at posedge+1 with the DUT idle; returns once out_valid is seen.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo);
    res_t r;
    chk("in_ready_idle", 32'(bus8.in_ready), 32'd1);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1;
    r.sum = es; r.cout = ec; r.ovf = eo;
    exp_q.push_back(r);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = ~a; bus8.b = ~b; bus8.cin = ~cin; bus8.sub = ~sub;
    wait_result(8);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
    issue(a, b, cin, sub, es, ec, eo);
    @(posedge clk); #1;
  endtask

  task automatic run_op4(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d4_latency", 32'(lat), 32'd2);
    chk("d4_sum", 32'(bus4.sum), 32'(es));
    chk("d4_cout", 32'(bus4.cout), 32'(ec));
    chk("d4_ovf", 32'(bus4.ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t r;
    bit   seen;
    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'h00);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    chk("rst_ovf", 32'(bus8.ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd1);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Abort in RUN at count 3; the partial sum is nonzero at that point.
    bus8.a = 8'h55; bus8.b = 8'h00; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'h00);
    chk("abort_cout", 32'(bus8.cout), 32'd0);
    chk("abort_ovf", 32'(bus8.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op(8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);

    // Back-pressure in DONE with competing operands.
    bus8.out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (10) begin
      bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
      @(posedge clk); #1;
      chk("hold_sum", 32'(bus8.sum), 32'h46);
      chk("hold_cout", 32'(bus8.cout), 32'd0);
      chk("hold_ovf", 32'(bus8.ovf), 32'd0);
      chk("hold_in_ready", 32'(bus8.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus8.out_valid), 32'd1);
    end
    bus8.out_ready = 1'b1;
    bus8.cin = 1'b0;
    r.sum = 8'hFF; r.cout = 1'b0; r.ovf = 1'b0;
    exp_q.push_back(r);
    @(posedge clk); #1;
    chk("release_in_ready", 32'(bus8.in_ready), 32'd1);
    chk("release_out_valid", 32'(bus8.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("accept_in_ready", 32'(bus8.in_ready), 32'd0);
    bus8.in_valid = 1'b0;
    wait_result(8);
    @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    run_op(8'hF0, 8'h10, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
`endif

    run_op4(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op4(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op4(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
